// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, registers the ROM word into IF/ID
// with a valid/ready handshake, handles redirects and latches the first fetch fault.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_RUN   | fetching; redirects, stalls and handshake honoured
// S_FAULT | bad target or PC seen; everything frozen until reset
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_DEPTH = 100
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Instr,
  input  logic        Stall,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Target,
  input  logic        Jump,
  input  logic [31:0] Jump_Target,
  input  logic        ID_Ready,
  output logic [31:0] PC,
  output logic        IF_Valid,
  output logic [31:0] IF_Instr,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_PCPlus4,
  output logic        Fault,
  output logic [1:0]  Fault_Cause,
  output logic [31:0] Fault_PC,
  output logic [31:0] Fetch_Count
);

  typedef enum logic {S_RUN, S_FAULT} state_t;

  localparam logic [1:0] CAUSE_NONE      = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN  = 2'b01;
  localparam logic [1:0] CAUSE_RANGE     = 2'b10;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        if_valid_q;
  logic [31:0] if_instr_q;
  logic [31:0] if_pc_q;
  logic [31:0] if_pc_plus4_q;
  logic        fault_q;
  logic [1:0]  fault_cause_q;
  logic [31:0] fault_pc_q;
  logic [31:0] fetch_count_q;

  logic        consume;
  logic        advance;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_word;
  logic        out_of_range;
  logic [31:0] pc_plus4_d;
  logic [31:0] fetch_count_d;

  always_comb begin
    consume       = if_valid_q & ID_Ready;
    advance       = ~Stall & (~if_valid_q | ID_Ready);
    redirect      = Jump | Branch_Taken;
    target        = Jump ? Jump_Target : Branch_Target;
    pc_word       = {2'b00, pc_q[31:2]};
    out_of_range  = (pc_word >= ROM_DEPTH);
    pc_plus4_d    = pc_q + 32'd4;
    fetch_count_d = fetch_count_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_RUN;
      pc_q          <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_instr_q    <= 32'd0;
      if_pc_q       <= 32'd0;
      if_pc_plus4_q <= 32'd0;
      fault_q       <= 1'b0;
      fault_cause_q <= CAUSE_NONE;
      fault_pc_q    <= 32'd0;
      fetch_count_q <= 32'd0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (redirect) begin
            // a redirect flushes IF/ID even while stalled or waiting on decode
            if_valid_q <= 1'b0;
            if (target[1:0] != 2'b00) begin
              state_q       <= S_FAULT;
              fault_q       <= 1'b1;
              fault_cause_q <= CAUSE_MISALIGN;
              fault_pc_q    <= target;
            end else begin
              pc_q <= target;
            end
          end else if (advance && out_of_range) begin
            state_q       <= S_FAULT;
            fault_q       <= 1'b1;
            fault_cause_q <= CAUSE_RANGE;
            fault_pc_q    <= pc_q;
            if (consume) if_valid_q <= 1'b0;
          end else if (advance) begin
            if_instr_q    <= Instr;
            if_pc_q       <= pc_q;
            if_pc_plus4_q <= pc_plus4_d;
            if_valid_q    <= 1'b1;
            pc_q          <= pc_plus4_d;
            fetch_count_q <= fetch_count_d;
          end else if (consume) begin
            if_valid_q <= 1'b0;
          end
        end
        default: begin
          if_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign PC          = pc_q;
  assign IF_Valid    = if_valid_q;
  assign IF_Instr    = if_instr_q;
  assign IF_PC       = if_pc_q;
  assign IF_PCPlus4  = if_pc_plus4_q;
  assign Fault       = fault_q;
  assign Fault_Cause = fault_cause_q;
  assign Fault_PC    = fault_pc_q;
  assign Fetch_Count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic, every cycle
// compared against a behavioural model of the fetch rules.
module tb_fetch_unit;

  localparam int unsigned ROM_DEPTH = 100;
  localparam int unsigned ROM_WORDS = 128;

  logic        clk_sys;
  logic        rst;
  logic [31:0] instr;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        id_ready;
  logic [31:0] pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  logic [31:0] rom [ROM_WORDS];

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic [31:0] m_pc, m_instr, m_ifpc, m_p4, m_fpc, m_cnt;
  logic        m_v, m_fault;
  logic [1:0]  m_cause;

  fetch_unit #(.RESET_PC(32'h0), .ROM_DEPTH(ROM_DEPTH)) dut (
    .CLK(clk_sys), .RST(rst), .Instr(instr), .Stall(stall),
    .Branch_Taken(br_taken), .Branch_Target(br_target),
    .Jump(jump), .Jump_Target(jump_target), .ID_Ready(id_ready),
    .PC(pc), .IF_Valid(if_valid), .IF_Instr(if_instr), .IF_PC(if_pc),
    .IF_PCPlus4(if_pc_plus4), .Fault(fault), .Fault_Cause(fault_cause),
    .Fault_PC(fault_pc), .Fetch_Count(fetch_count)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  function automatic logic [31:0] rom_read(input logic [31:0] addr);
    logic [31:0] w;
    w = addr >> 2;
    if (w < ROM_WORDS) return rom[w[6:0]];
    return 32'h0;
  endfunction

  always_comb instr = rom_read(pc);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    logic        consume, adv;
    logic [31:0] t;
    if (rst) begin
      m_pc = 0; m_v = 0; m_instr = 0; m_ifpc = 0; m_p4 = 0;
      m_fault = 0; m_cause = 0; m_fpc = 0; m_cnt = 0;
      return;
    end
    if (m_fault) begin
      m_v = 0;
      return;
    end
    consume = m_v && id_ready;
    adv     = !stall && (!m_v || id_ready);
    if (jump || br_taken) begin
      t   = jump ? jump_target : br_target;
      m_v = 0;
      if (t % 4 != 0) begin
        m_fault = 1; m_cause = 2'd1; m_fpc = t;
      end else begin
        m_pc = t;
      end
    end else if (adv && (m_pc / 4) >= ROM_DEPTH) begin
      m_fault = 1; m_cause = 2'd2; m_fpc = m_pc;
      if (consume) m_v = 0;
    end else if (adv) begin
      m_instr = rom_read(m_pc);
      m_ifpc  = m_pc;
      m_p4    = m_pc + 4;
      m_v     = 1;
      m_pc    = m_pc + 4;
      m_cnt   = m_cnt + 1;
    end else if (consume) begin
      m_v = 0;
    end
  endtask

  task automatic compare_all();
    check("PC", pc, m_pc);
    check("IF_Valid", {31'd0, if_valid}, {31'd0, m_v});
    check("Fault", {31'd0, fault}, {31'd0, m_fault});
    check("Fault_Cause", {30'd0, fault_cause}, {30'd0, m_cause});
    check("Fault_PC", fault_pc, m_fpc);
    check("Fetch_Count", fetch_count, m_cnt);
    if (m_v) begin
      check("IF_Instr", if_instr, m_instr);
      check("IF_PC", if_pc, m_ifpc);
      check("IF_PCPlus4", if_pc_plus4, m_p4);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic b, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt, input logic rdy);
    @(negedge clk_sys);
    rst = r; stall = s; br_taken = b; br_target = bt;
    jump = j; jump_target = jt; id_ready = rdy;
    model_step();
    @(posedge clk_sys);
    #1;
    compare_all();
  endtask

  task automatic run(input int n, input logic s, input logic rdy);
    for (int i = 0; i < n; i++) step(0, s, 0, 0, 0, 0, rdy);
  endtask

  initial begin
    for (int i = 0; i < ROM_WORDS; i++) rom[i] = $urandom;
    rom[0] = 32'h2008_0005; rom[1] = 32'h2009_0003;
    rom[2] = 32'h0109_5020; rom[3] = 32'hAC0A_0000;
    rst = 1; stall = 0; br_taken = 0; br_target = 0;
    jump = 0; jump_target = 0; id_ready = 0;

    // reset and straight-line fetch
    step(1, 0, 0, 0, 0, 0, 1);
    check("reset_pc", pc, 32'h0);
    check("reset_cnt", fetch_count, 32'h0);
    step(0, 0, 0, 0, 0, 0, 1);
    check("first_instr", if_instr, 32'h2008_0005);
    run(3, 0, 1);
    check("run4_pc", pc, 32'h10);
    check("run4_cnt", fetch_count, 32'd4);
    check("run4_instr", if_instr, 32'hAC0A_0000);

    // stall at PC=8 with decode consuming
    step(1, 0, 0, 0, 0, 0, 1);
    run(2, 0, 1);
    run(2, 1, 1);
    check("stall_pc", pc, 32'h8);
    check("stall_valid", {31'd0, if_valid}, 32'd0);
    run(1, 0, 1);
    check("release_instr", if_instr, 32'h0109_5020);
    check("release_ifpc", if_pc, 32'h8);

    // decode back-pressure holds IF/ID
    step(1, 0, 0, 0, 0, 0, 1);
    run(2, 0, 1);
    run(3, 0, 0);
    check("bp_ifpc", if_pc, 32'h4);
    check("bp_pc", pc, 32'h8);
    check("bp_cnt", fetch_count, 32'd2);

    // jump beats branch and stall
    step(0, 1, 1, 32'h20, 1, 32'h10, 0);
    check("jump_pc", pc, 32'h10);
    check("jump_flush", {31'd0, if_valid}, 32'd0);
    run(1, 0, 1);
    check("jump_capture", if_pc, 32'h10);

    // misaligned branch target
    step(0, 0, 1, 32'h22, 0, 0, 1);
    check("mis_cause", {30'd0, fault_cause}, 32'd1);
    check("mis_fpc", fault_pc, 32'h22);
    step(0, 0, 0, 0, 1, 32'h40, 1);
    check("mis_frozen_pc", pc, 32'h14);
    step(1, 0, 0, 0, 0, 0, 1);
    check("mis_reset_fault", {31'd0, fault}, 32'd0);

    // run off the end of the ROM
    run(100, 0, 1);
    check("oor_pc", pc, 32'h190);
    check("oor_cnt", fetch_count, 32'd100);
    check("oor_last_ifpc", if_pc, 32'h18C);
    run(1, 0, 1);
    check("oor_cause", {30'd0, fault_cause}, 32'd2);
    check("oor_fpc", fault_pc, 32'h190);
    check("oor_cnt_frozen", fetch_count, 32'd100);

    // random traffic
    step(1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4000; i++) begin
      logic        r, s, b, j, rdy;
      logic [31:0] bt, jt;
      r   = ($urandom_range(0, 99) < 2) || (m_fault && $urandom_range(0, 7) == 0);
      s   = $urandom_range(0, 3) == 0;
      rdy = $urandom_range(0, 3) != 0;
      b   = $urandom_range(0, 19) == 0;
      j   = $urandom_range(0, 29) == 0;
      bt  = $urandom_range(0, 104) * 4;
      jt  = $urandom_range(0, 104) * 4;
      if ($urandom_range(0, 9) == 0) bt = bt + $urandom_range(1, 3);
      if ($urandom_range(0, 9) == 0) jt = jt + $urandom_range(1, 3);
      step(r, s, b, bt, j, jt, rdy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch front end that sits directly upstream of the instruction ROM. It owns the program counter and drives PC to the ROM, which returns Instr combinationally. It captures Instr into a registered IF/ID output with a valid/ready handshake to decode. It handles stall, branch/jump redirect with flush, and sticky fault detection for misaligned or out-of-range fetch addresses.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
ROM_DEPTH, 100, number of 32-bit words in the instruction ROM; word index >= ROM_DEPTH is out of range

Ports:
CLK  input  1  single clock, all state updates on rising edge
RST  input  1  synchronous reset, active-high
Instr  input  32  instruction word returned combinationally by the ROM for the current PC
Stall  input  1  hazard stall from downstream; blocks PC advance
Branch_Taken  input  1  redirect request to Branch_Target
Branch_Target  input  32  branch destination byte address
Jump  input  1  redirect request to Jump_Target; has priority over Branch_Taken
Jump_Target  input  32  jump destination byte address
ID_Ready  input  1  decode accepts IF_* this cycle
PC  output  32  current fetch address, driven to ROM
IF_Valid  output  1  IF_* holds a valid fetched instruction
IF_Instr  output  32  registered instruction
IF_PC  output  32  address of IF_Instr
IF_PCPlus4  output  32  IF_PC + 4
Fault  output  1  sticky fetch fault
Fault_Cause  output  2  00 none, 01 misaligned redirect target, 10 PC out of range
Fault_PC  output  32  offending address
Fetch_Count  output  32  number of instructions captured into IF_* since reset

Behaviour:
- Reset (RST=1 at edge): PC=RESET_PC, IF_Valid=0, IF_Instr=0, IF_PC=0, IF_PCPlus4=0, Fault=0, Fault_Cause=00, Fault_PC=0, Fetch_Count=0, state=RUN.
- Reset has priority over every other input. It takes effect mid-stall, mid-redirect or in FAULT.
- States: RUN, FAULT. RUN->FAULT on the fault conditions below. FAULT is left only by reset.
- Definitions:
  - consume = IF_Valid & ID_Ready.
  - advance = ~Stall & (~IF_Valid | ID_Ready).
  - redirect = Jump | Branch_Taken.
  - target = Jump ? Jump_Target : Branch_Target.
- RUN, priority per cycle: redirect > out-of-range check > advance > hold.
- Redirect:
  - If target[1:0]!=0: go to FAULT, Fault_Cause=01, Fault_PC=target, PC unchanged.
  - Otherwise: PC<=target.
  - In both cases IF_Valid<=0 (flush), Fetch_Count unchanged.
  - Redirect overrides Stall and any pending IF_* contents.
- Out of range: if advance and (PC>>2) >= ROM_DEPTH, go to FAULT, Fault_Cause=10, Fault_PC=PC. Nothing is captured, and IF_Valid<=0 if consume, else it holds.
- Advance (in range):
  - IF_Instr<=Instr, IF_PC<=PC, IF_PCPlus4<=PC+4, IF_Valid<=1.
  - PC<=PC+4, Fetch_Count<=Fetch_Count+1.
- Hold (no advance): PC and IF_* unchanged, except IF_Valid<=0 when consume. This covers Stall with decode consuming.
- Latency: an instruction at PC appears on IF_Instr one cycle after PC is presented. With no stalls, throughput is one instruction per cycle.
- Handshake: IF_* stable while IF_Valid=1 and ID_Ready=0.
- FAULT: PC, Fault_* and Fetch_Count frozen. IF_Valid<=0. All requests ignored.
- Arithmetic: PC+4 and Fetch_Count wrap modulo 2^32 with no flag.
- The fault registers capture only the first fault.

Test Plan:
- Reset, then run 4 cycles with ID_Ready=1, Stall=0, and ROM words 0..3 = 0x20080005, 0x20090003, 0x01095020, 0xAC0A0000.
  -> PC sequence 0,4,8,C,10.
  -> IF_Instr one cycle behind.
  -> Fetch_Count=4.
- Stall=1 for 2 cycles at PC=8 with ID_Ready=1.
  -> PC stays 8.
  -> IF_Valid drops to 0 after the first consume.
  -> On release, IF_Instr=0x01095020, IF_PC=8.
- ID_Ready=0 for 3 cycles with IF_Valid=1 at IF_PC=4.
  -> IF_* frozen and PC stays 8.
  -> Fetch_Count unchanged.
- Jump=1, Jump_Target=0x10 and Branch_Taken=1, Branch_Target=0x20 in the same cycle, together with Stall=1.
  -> PC=0x10 next cycle.
  -> IF_Valid=0 for that cycle.
  -> The following capture has IF_PC=0x10.
- Branch_Taken=1, Branch_Target=0x22.
  -> Fault=1, Fault_Cause=01, Fault_PC=0x22.
  -> PC frozen and IF_Valid=0.
  -> A later Jump is ignored, and RST=1 restores PC=0, Fault=0.
- Run sequentially to PC=0x190 (word 100) with ROM_DEPTH=100.
  -> Fault=1, Fault_Cause=10, Fault_PC=0x190.
  -> Last valid IF_PC=0x18C.
  -> Fetch_Count=100.
